// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative signed/unsigned
// multiply and divide into HI/LO, with a start/busy/done handshake.
module alu_mc #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       Func,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] O,
  output logic             OV,
  output logic             CO,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             DZ,
  output logic             busy,
  output logic             done
);

  localparam logic [5:0] F_ADD   = 6'b000010;
  localparam logic [5:0] F_SUB   = 6'b000100;
  localparam logic [5:0] F_AND   = 6'b001000;
  localparam logic [5:0] F_OR    = 6'b010000;
  localparam logic [5:0] F_NOR   = 6'b100000;
  localparam logic [5:0] F_NAND  = 6'b000011;
  localparam logic [5:0] F_XOR   = 6'b010001;
  localparam logic [5:0] F_SLTU  = 6'b000101;
  localparam logic [5:0] F_SLT   = 6'b001001;
  localparam logic [5:0] F_EQ    = 6'b100001;
  localparam logic [5:0] F_NE    = 6'b100011;
  localparam logic [5:0] F_SLL   = 6'b001100;
  localparam logic [5:0] F_SRL   = 6'b001101;
  localparam logic [5:0] F_SRA   = 6'b001110;
  localparam logic [5:0] F_MULTU = 6'b000110;
  localparam logic [5:0] F_MULT  = 6'b000111;
  localparam logic [5:0] F_DIVU  = 6'b001010;
  localparam logic [5:0] F_DIV   = 6'b001011;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

  state_e           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] o_q, o_d, hi_q, hi_d, lo_q, lo_d;
  logic             ov_q, ov_d, co_q, co_d, dz_q, dz_d, done_q, done_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, mag_q, mag_d;
  logic             neg_q, neg_d, sa_q, sa_d, div_q, div_d;

  logic [WIDTH:0]   add_r, sub_r;
  logic [WIDTH-1:0] sc_o;
  logic             sc_ov, sc_co;
  logic             is_md, is_div, signed_op;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum, div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_df, quo_f, rem_f;
  logic [2*WIDTH-1:0] prod_f;

  assign add_r = {1'b0, A} + {1'b0, B};
  assign sub_r = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);

  always_comb begin
    sc_o  = '0;
    sc_ov = 1'b0;
    sc_co = 1'b0;
    case (Func)
      F_ADD: begin
        sc_o  = add_r[WIDTH-1:0];
        sc_co = add_r[WIDTH];
        sc_ov = (A[WIDTH-1] == B[WIDTH-1]) && (add_r[WIDTH-1] != A[WIDTH-1]);
      end
      F_SUB: begin
        sc_o  = sub_r[WIDTH-1:0];
        sc_co = sub_r[WIDTH];
        sc_ov = (A[WIDTH-1] != B[WIDTH-1]) && (sub_r[WIDTH-1] != A[WIDTH-1]);
      end
      F_AND:  sc_o = A & B;
      F_OR:   sc_o = A | B;
      F_NOR:  sc_o = ~(A | B);
      F_NAND: sc_o = ~(A & B);
      F_XOR:  sc_o = A ^ B;
      F_SLTU: sc_o = {{(WIDTH-1){1'b0}}, A < B};
      F_SLT:  sc_o = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      F_EQ:   sc_ov = (A == B);
      F_NE:   sc_ov = (A != B);
      F_SLL:  sc_o = A << B[SHW-1:0];
      F_SRL:  sc_o = A >> B[SHW-1:0];
      F_SRA:  sc_o = $unsigned($signed(A) >>> B[SHW-1:0]);
      default: ;
    endcase
  end

  assign is_md     = (Func == F_MULTU) || (Func == F_MULT) || (Func == F_DIVU) || (Func == F_DIV);
  assign is_div    = (Func == F_DIVU) || (Func == F_DIV);
  assign signed_op = (Func == F_MULT) || (Func == F_DIV);
  assign abs_a     = (signed_op && A[WIDTH-1]) ? -A : A;
  assign abs_b     = (signed_op && B[WIDTH-1]) ? -B : B;

  // Shared datapath: mult keeps multiplicand in mag_q and multiplier/low product
  // in acc_lo_q; div keeps divisor in mag_q, dividend/quotient in acc_lo_q.
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_q} : '0);
  assign div_sh  = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_ge  = div_sh >= {1'b0, mag_q};
  assign div_df  = div_sh[WIDTH-1:0] - mag_q;
  assign prod_f  = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
  assign quo_f   = neg_q ? -acc_lo_q : acc_lo_q;
  assign rem_f   = sa_q ? -acc_hi_q : acc_hi_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    o_d      = o_q;
    ov_d     = ov_q;
    co_d     = co_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    mag_d    = mag_q;
    neg_d    = neg_q;
    sa_d     = sa_q;
    div_d    = div_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!is_md) begin
            o_d    = sc_o;
            ov_d   = sc_ov;
            co_d   = sc_co;
            done_d = 1'b1;
          end else if (is_div && (B == '0)) begin
            lo_d   = '1;
            hi_d   = A;
            dz_d   = 1'b1;
            done_d = 1'b1;
          end else begin
            mag_d    = is_div ? abs_b : abs_a;
            acc_lo_d = is_div ? abs_a : abs_b;
            acc_hi_d = '0;
            neg_d    = signed_op && (A[WIDTH-1] ^ B[WIDTH-1]);
            sa_d     = signed_op && A[WIDTH-1];
            div_d    = is_div;
            cnt_d    = '0;
            state_d  = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (div_q) begin
          acc_hi_d = div_ge ? div_df : div_sh[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
        end else begin
          acc_hi_d = mul_sum[WIDTH:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH-1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (div_q) begin
          lo_d = quo_f;
          hi_d = rem_f;
        end else begin
          {hi_d, lo_d} = prod_f;
        end
        dz_d    = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      o_q      <= '0;
      ov_q     <= 1'b0;
      co_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      mag_q    <= '0;
      neg_q    <= 1'b0;
      sa_q     <= 1'b0;
      div_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      o_q      <= o_d;
      ov_q     <= ov_d;
      co_q     <= co_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      mag_q    <= mag_d;
      neg_q    <= neg_d;
      sa_q     <= sa_d;
      div_q    <= div_d;
    end
  end

  assign O    = o_q;
  assign OV   = ov_q;
  assign CO   = co_q;
  assign HI   = hi_q;
  assign LO   = lo_q;
  assign DZ   = dz_q;
  assign busy = (state_q != S_IDLE);
  assign done = done_q;

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the multi-cycle MIPS datapath; the successor to the single-cycle combinational ALU.

- Keeps the existing 6-bit `Func` encodings.
- Adds: width parameter, registered results with a start/busy/done handshake, true signed overflow plus a separate carry-out, shifts, and iterative signed/unsigned multiply/divide writing HI/LO.
- Sits between the register-file operand latches and the ALUOut/HI/LO write-back in the control FSM.

## Interface
- `WIDTH`, 32: operand/result width, ≥ 8, power of two.
- `SHW`, log2(WIDTH): shift-amount width.

Ports (the rule below is already decided and fixed):
- `clk  in  1`: single clock; all state updates on its rising edge.
- `rst_n  in  1`: synchronous, active-low reset.
- `start  in  1`: request; sampled only when `busy`=0.
- `Func  in  6`: operation code.
- `A, B  in  WIDTH`: operands, latched on the accepted `start`.
- `O  out  WIDTH`: primary result.
- `OV  out  1`: signed overflow (add/sub) or compare flag (eq/ne).
- `CO  out  1`: carry-out of add, or no-borrow of sub.
- `HI, LO  out  WIDTH`: multiply product high/low; divide remainder/quotient.
- `DZ  out  1`: divide by zero occurred.
- `busy  out  1`: operation in flight; `start` is ignored while high.
- `done  out  1`: one-cycle pulse; results valid from this cycle.

## Operation
Func codes and results:
- 000010 add: O=A+B; CO=carry; OV=signed overflow.
- 000100 sub: O=A−B; CO=no-borrow; OV=signed overflow.
- 001000 and; 010000 or; 100000 nor; 000011 nand; 010001 xor.
- 000101 sltu: O={0…,A<B unsigned}.
- 001001 slt: O={0…,A<B signed}.
- 100001 eq: OV=(A==B), O=0.
- 100011 ne: OV=(A!=B), O=0.
- 001100 sll, 001101 srl, 001110 sra: O=A shifted by B[SHW-1:0].
- 000110 multu, 000111 mult: {HI,LO}=A×B (2·WIDTH bits).
- 001010 divu, 001011 div: LO=quotient, HI=remainder.
- Any other code: O=0, OV=0, CO=0; `done` still pulses.

Register behaviour:
- Each completing op updates only its own outputs. O/OV/CO are updated by single-cycle ops; HI/LO/DZ are updated by mult/div.
- All result outputs hold until they are overwritten.

FSM:
- States: IDLE, CALC, FIX.
- IDLE + `start`, single-cycle op: compute and register the result; `done`=1 next cycle; stay IDLE.
- IDLE + `start`, mult/div: latch operand magnitudes (signed variants take |A|, |B| and record signs); clear the iteration counter; go to CALC.
- CALC: one shift-add (mult) or restoring shift-subtract (div) step per cycle. After WIDTH steps go to FIX.
- FIX: apply sign correction and register HI/LO. Return to IDLE with `done`=1.
- Signed mult: negate the 2·WIDTH product when sign(A)≠sign(B).
- Signed div: quotient negated when the signs differ; remainder takes the sign of A.
- MIN/−1 divide: LO=MIN, HI=0, no flag.
- Divide with B=0: skip CALC; LO=all ones, HI=A, DZ=1; 1-cycle latency. Any other mult/div clears DZ.

## Timing
Latency, with `start` accepted at edge k:
- Single-cycle ops: `done` high in the cycle following edge k.
- Mult/div: `done` high in the cycle following edge k+WIDTH+1.
- For mult/div, `busy`=1 in the WIDTH+1 cycles before `done`, and 0 in the `done` cycle.

Handshake:
- `start` while `busy`=1 is ignored; it is not queued.
- `start` in the `done` cycle is accepted, giving back-to-back issue.
- Single-cycle ops never assert `busy`.
- Operands may change after the accepting edge without affecting the result.

Reset:
- `rst_n`=0 at any edge, including mid-CALC: state→IDLE and the counter is cleared.
- Reset value 0 for O, OV, CO, HI, LO, DZ, busy and done.
- An aborted operation never pulses `done`.

## Test plan
1. **Add overflow.** WIDTH=32, add with A=0x7FFFFFFF, B=1 → O=0x80000000, OV=1, CO=0, `done` at k+1. Then sub with A=0, B=1 → O=0xFFFFFFFF, CO=0, OV=0.
2. **Compares.** slt with A=0xFFFFFFFF, B=1 → O=1. sltu with the same operands → O=0. eq with A=B=0x1234 → OV=1. ne → OV=0.
3. **Signed multiply.** mult with A=0xFFFFFFFE, B=3 → HI=0xFFFFFFFF, LO=0xFFFFFFFA. `busy` high k+1…k+33, `done` at k+34. A `start`(add) at k+5 is ignored and O is unchanged. A `start`(add) in the `done` cycle completes one cycle later.
4. **Divide.**
   - div A=−7, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
   - divu A=7, B=0 → DZ=1, LO=0xFFFFFFFF, HI=7, `done` at k+1.
   - div A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
5. **Reset mid-multiply.** `rst_n`=0 at k+10 of a multu → next cycle `busy`=0 and HI=LO=0; `done` never pulses. A new multu 5×6 then gives LO=30, HI=0.
6. **Shifts and unknown code.**
   - sra A=0x80000000, B=4 → O=0xF8000000.
   - srl with the same operands → 0x08000000.
   - sll A=1, B=0x21 → O=2 (only B[4:0] is used).
   - Func=111111 → O=0, `done` pulses.
